// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the accumulator CPU control unit: control-bit
// positions, opcodes, sequencer states and decoded instruction classes.
package cpu_ctrl_pkg;

   localparam int CTRL_W = 32;

   localparam logic [4:0] CB_MEM_RD      = 5'd0;
   localparam logic [4:0] CB_PC_MBR      = 5'd1;
   localparam logic [4:0] CB_PC_MAR      = 5'd2;
   localparam logic [4:0] CB_MBR_PC      = 5'd3;
   localparam logic [4:0] CB_MBR_IR      = 5'd4;
   localparam logic [4:0] CB_IR_ADDR_MAR = 5'd5;
   localparam logic [4:0] CB_MEM_WR      = 5'd6;
   localparam logic [4:0] CB_ACC_MBR     = 5'd7;
   localparam logic [4:0] CB_MBR_BR      = 5'd8;
   localparam logic [4:0] CB_ADD         = 5'd9;
   localparam logic [4:0] CB_SUB         = 5'd10;
   localparam logic [4:0] CB_AND         = 5'd11;
   localparam logic [4:0] CB_OR          = 5'd12;
   localparam logic [4:0] CB_NOT         = 5'd13;
   localparam logic [4:0] CB_SHL         = 5'd14;
   localparam logic [4:0] CB_SHR         = 5'd15;
   localparam logic [4:0] CB_BR_ACC      = 5'd16;
   localparam logic [4:0] CB_ACC_CLR     = 5'd17;
   localparam logic [4:0] CB_MPY         = 5'd18;
   localparam logic [4:0] CB_PC_INC      = 5'd20;

   localparam logic [7:0] OP_STORE  = 8'h01;
   localparam logic [7:0] OP_LOAD   = 8'h02;
   localparam logic [7:0] OP_ADD    = 8'h03;
   localparam logic [7:0] OP_SUB    = 8'h04;
   localparam logic [7:0] OP_JMPGEZ = 8'h05;
   localparam logic [7:0] OP_JMP    = 8'h06;
   localparam logic [7:0] OP_HALT   = 8'h07;
   localparam logic [7:0] OP_MPY    = 8'h08;
   localparam logic [7:0] OP_AND    = 8'h0A;
   localparam logic [7:0] OP_OR     = 8'h0B;
   localparam logic [7:0] OP_NOT    = 8'h0C;
   localparam logic [7:0] OP_SHR    = 8'h0D;
   localparam logic [7:0] OP_SHL    = 8'h0E;

   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_F0   = 4'd1,
      ST_F1   = 4'd2,
      ST_F1W  = 4'd3,
      ST_F2   = 4'd4,
      ST_DEC  = 4'd5,
      ST_E0   = 4'd6,
      ST_E1   = 4'd7,
      ST_E2   = 4'd8,
      ST_E3   = 4'd9,
      ST_EW   = 4'd10,
      ST_HALT = 4'd11
   } state_t;

   typedef enum logic [3:0] {
      CL_ILLEGAL, CL_LOAD, CL_STORE, CL_ALU_MEM, CL_MPY,
      CL_ALU_REG, CL_JMP, CL_JMPGEZ, CL_HALT
   } op_class_t;

   function automatic logic [CTRL_W-1:0] cbit(input logic [4:0] idx);
      logic [CTRL_W-1:0] w;
      w = '0;
      w[idx] = 1'b1;
      return w;
   endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational opcode decoder: classifies the IR opcode and picks the ALU
// control bit used by the arithmetic/logic instructions.
module cu_decoder
   import cpu_ctrl_pkg::*;
(
   input  logic [7:0] opcode_i,
   output op_class_t  class_o,
   output logic [4:0] alu_bit_o,
   output logic       legal_o
);

   always_comb begin
      class_o   = CL_ILLEGAL;
      alu_bit_o = CB_ADD;
      legal_o   = 1'b1;
      case (opcode_i)
         OP_STORE:  class_o = CL_STORE;
         OP_LOAD:   class_o = CL_LOAD;
         OP_ADD:    begin class_o = CL_ALU_MEM; alu_bit_o = CB_ADD; end
         OP_SUB:    begin class_o = CL_ALU_MEM; alu_bit_o = CB_SUB; end
         OP_AND:    begin class_o = CL_ALU_MEM; alu_bit_o = CB_AND; end
         OP_OR:     begin class_o = CL_ALU_MEM; alu_bit_o = CB_OR;  end
         OP_MPY:    begin class_o = CL_MPY;     alu_bit_o = CB_MPY; end
         OP_NOT:    begin class_o = CL_ALU_REG; alu_bit_o = CB_NOT; end
         OP_SHR:    begin class_o = CL_ALU_REG; alu_bit_o = CB_SHR; end
         OP_SHL:    begin class_o = CL_ALU_REG; alu_bit_o = CB_SHL; end
         OP_JMP:    class_o = CL_JMP;
         OP_JMPGEZ: class_o = CL_JMPGEZ;
         OP_HALT:   class_o = CL_HALT;
         default:   legal_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/cu_sequencer.sv
// Microprogrammed fetch/decode/execute sequencer. The control word is
// registered from the next state, so the word seen on the bus belongs to the current state.
module cu_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int CW          = 32,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          run,
   input  logic [7:0]    ir_opcode,
   input  logic          acc_neg,
   input  logic          mem_ready,
   input  logic          alu_busy,
   output logic [CW-1:0] control_signal,
   output logic          halted,
   output logic          illegal_op,
   output logic          bus_error,
   output logic [3:0]    fsm_state
);

   localparam logic [7:0] TO_CNT = 8'(MEM_TIMEOUT - 1);

   state_t          state_q, state_d, end_state;
   op_class_t       class_q, class_d, dec_class;
   logic [4:0]      alu_q, alu_d, dec_alu;
   logic            dec_legal;
   logic            alu_wait_q, alu_wait_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [CW-1:0]   word_q, word_d;
   logic            halted_q, halted_d, illegal_q, illegal_d, buserr_q, buserr_d;
   logic            mem_timeout;

   cu_decoder u_dec (
      .opcode_i  (ir_opcode),
      .class_o   (dec_class),
      .alu_bit_o (dec_alu),
      .legal_o   (dec_legal)
   );

   function automatic logic [CW-1:0] cw(input logic [4:0] idx);
      return CW'(cbit(idx));
   endfunction

   always_comb begin
      state_d     = state_q;
      class_d     = class_q;
      alu_d       = alu_q;
      alu_wait_d  = alu_wait_q;
      halted_d    = halted_q;
      illegal_d   = illegal_q;
      buserr_d    = buserr_q;
      word_d      = '0;
      cnt_d       = cnt_q;
      end_state   = run ? ST_F0 : ST_IDLE;
      mem_timeout = !mem_ready && (cnt_q == TO_CNT);

      case (state_q)
         ST_IDLE: if (run) state_d = ST_F0;
         ST_F0:   state_d = ST_F1;
         ST_F1:   state_d = ST_F1W;
         ST_F1W: begin
            if (mem_ready) state_d = ST_F2;
            else if (mem_timeout) begin
               buserr_d = 1'b1;
               halted_d = 1'b1;
               state_d  = ST_HALT;
            end
         end
         ST_F2:   state_d = ST_DEC;
         ST_DEC: begin
            class_d = dec_class;
            alu_d   = dec_alu;
            if (!dec_legal || dec_class == CL_ILLEGAL) begin
               illegal_d = 1'b1;
               halted_d  = 1'b1;
               state_d   = ST_HALT;
            end else if (dec_class == CL_HALT) begin
               halted_d = 1'b1;
               state_d  = ST_HALT;
            end else begin
               state_d = ST_E0;
            end
         end
         ST_E0: begin
            if (class_q inside {CL_LOAD, CL_STORE, CL_ALU_MEM, CL_MPY}) state_d = ST_E1;
            else state_d = end_state;
         end
         ST_E1: begin
            alu_wait_d = 1'b0;
            state_d    = (class_q == CL_STORE) ? ST_E2 : ST_EW;
         end
         ST_E2: state_d = (class_q == CL_STORE) ? ST_EW : ST_E3;
         ST_E3: begin
            if (class_q == CL_MPY) begin
               alu_wait_d = 1'b1;
               state_d    = ST_EW;
            end else begin
               state_d = end_state;
            end
         end
         ST_EW: begin
            // The same wait state serves both memory completion and the MPY busy phase.
            if (alu_wait_q) begin
               if (!alu_busy) state_d = end_state;
            end else if (mem_ready) begin
               state_d = (class_q == CL_STORE) ? end_state : ST_E2;
            end else if (mem_timeout) begin
               buserr_d = 1'b1;
               halted_d = 1'b1;
               state_d  = ST_HALT;
            end
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase

      case (state_d)
         ST_F0:  word_d = cw(CB_PC_MAR);
         ST_F1:  word_d = cw(CB_MEM_RD) | cw(CB_PC_INC);
         ST_F2:  word_d = cw(CB_MBR_IR);
         ST_E0: begin
            case (class_d)
               CL_JMP:     word_d = cw(CB_MBR_PC);
               CL_JMPGEZ:  word_d = acc_neg ? '0 : cw(CB_MBR_PC);
               CL_ALU_REG: word_d = cw(alu_d);
               default:    word_d = cw(CB_IR_ADDR_MAR);
            endcase
         end
         ST_E1:  word_d = (class_d == CL_STORE) ? cw(CB_ACC_MBR) : cw(CB_MEM_RD);
         ST_E2:  word_d = (class_d == CL_STORE) ? cw(CB_MEM_WR) : cw(CB_MBR_BR);
         ST_E3:  word_d = (class_d == CL_LOAD) ? cw(CB_BR_ACC) : cw(alu_d);
         default: word_d = '0;
      endcase

      // Counts cycles since the last memory pulse; saturates instead of wrapping.
      if (word_d[CB_MEM_RD] || word_d[CB_MEM_WR]) cnt_d = '0;
      else if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         class_q    <= CL_ILLEGAL;
         alu_q      <= '0;
         alu_wait_q <= 1'b0;
         cnt_q      <= '0;
         word_q     <= '0;
         halted_q   <= 1'b0;
         illegal_q  <= 1'b0;
         buserr_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         class_q    <= class_d;
         alu_q      <= alu_d;
         alu_wait_q <= alu_wait_d;
         cnt_q      <= cnt_d;
         word_q     <= word_d;
         halted_q   <= halted_d;
         illegal_q  <= illegal_d;
         buserr_q   <= buserr_d;
      end
   end

   assign control_signal = word_q;
   assign halted         = halted_q;
   assign illegal_op     = illegal_q;
   assign bus_error      = buserr_q;
   assign fsm_state      = state_q;

endmodule

// File: tb/tb_cu_sequencer.sv
// Bench for cu_sequencer: table of single instructions plus hand-written
// sequences for reset, memory/ALU latency, run drop, timeout and halt.
module tb_cu_sequencer;

   localparam int MEM_TIMEOUT = 255;
   localparam logic [3:0] S_IDLE = 4'd0;
   localparam logic [3:0] S_F1W  = 4'd3;
   localparam logic [3:0] S_HALT = 4'd11;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic [7:0]  ir_opcode;
   logic        acc_neg;
   logic        mem_ready = 1'b0;
   logic        alu_busy = 1'b0;
   logic [31:0] control_signal;
   logic        halted, illegal_op, bus_error;
   logic [3:0]  fsm_state;

   int n_cmp = 0;
   int n_fail = 0;
   int pc_inc_cnt = 0;
   int n_instr = 0;
   int mem_lat = 1;
   int mpy_lat = 0;
   bit mem_en = 1'b1;
   int since = 1000;
   int busy_left = 0;

   logic [31:0] exp_q[$];

   typedef struct {
      logic [7:0]       op;
      logic             neg;
      int               n;
      logic [5:0][31:0] w;
   } vec_t;

   vec_t vecs[13];

   cu_sequencer #(.CW(32), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk            (clk),
      .rst            (rst),
      .run            (run),
      .ir_opcode      (ir_opcode),
      .acc_neg        (acc_neg),
      .mem_ready      (mem_ready),
      .alu_busy       (alu_busy),
      .control_signal (control_signal),
      .halted         (halted),
      .illegal_op     (illegal_op),
      .bus_error      (bus_error),
      .fsm_state      (fsm_state)
   );

   always #5 clk = ~clk;

   // Memory answers mem_lat cycles after a MEM pulse; the ALU stays busy
   // for mpy_lat cycles starting with the MPY pulse cycle.
   always @(negedge clk) begin
      if (control_signal[0] || control_signal[6]) since = 0;
      else if (since < 1000) since = since + 1;
      mem_ready = mem_en && (since >= mem_lat);
      if (control_signal[18]) busy_left = mpy_lat;
      if (busy_left > 0) begin
         alu_busy  = 1'b1;
         busy_left = busy_left - 1;
      end else begin
         alu_busy = 1'b0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input logic [31:0] w);
      logic [31:0] e;
      exp_q.push_back(w);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("word@%0t", $time), control_signal, e);
      if (control_signal[20]) pc_inc_cnt++;
   endtask

   task automatic fetch(input logic [7:0] op, input logic neg);
      ir_opcode = op;
      acc_neg   = neg;
      n_instr++;
      tick(32'h4);
      tick(32'h0010_0001);
      for (int i = 0; i < mem_lat; i++) tick(32'h0);
      tick(32'h10);
      tick(32'h0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic vec_t mk(input logic [7:0] op, input logic neg, input int n,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                               input logic [31:0] d, input logic [31:0] e, input logic [31:0] f);
      vec_t v;
      v.op = op; v.neg = neg; v.n = n;
      v.w[0] = a; v.w[1] = b; v.w[2] = c; v.w[3] = d; v.w[4] = e; v.w[5] = f;
      return v;
   endfunction

   initial begin
      vecs[0]  = mk(8'h02, 1'b0, 5, 32'h20, 32'h1, 32'h0, 32'h100, 32'h10000, 32'h0);
      vecs[1]  = mk(8'h01, 1'b0, 4, 32'h20, 32'h80, 32'h40, 32'h0, 32'h0, 32'h0);
      vecs[2]  = mk(8'h03, 1'b0, 5, 32'h20, 32'h1, 32'h0, 32'h100, 32'h200, 32'h0);
      vecs[3]  = mk(8'h04, 1'b1, 5, 32'h20, 32'h1, 32'h0, 32'h100, 32'h400, 32'h0);
      vecs[4]  = mk(8'h0A, 1'b0, 5, 32'h20, 32'h1, 32'h0, 32'h100, 32'h800, 32'h0);
      vecs[5]  = mk(8'h0B, 1'b0, 5, 32'h20, 32'h1, 32'h0, 32'h100, 32'h1000, 32'h0);
      vecs[6]  = mk(8'h08, 1'b0, 6, 32'h20, 32'h1, 32'h0, 32'h100, 32'h40000, 32'h0);
      vecs[7]  = mk(8'h0C, 1'b0, 1, 32'h2000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
      vecs[8]  = mk(8'h0D, 1'b0, 1, 32'h8000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
      vecs[9]  = mk(8'h0E, 1'b0, 1, 32'h4000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
      vecs[10] = mk(8'h06, 1'b1, 1, 32'h8, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
      vecs[11] = mk(8'h05, 1'b0, 1, 32'h8, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
      vecs[12] = mk(8'h05, 1'b1, 1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

      rst = 1'b1; run = 1'b0; ir_opcode = 8'h00; acc_neg = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_word", control_signal, 32'h0);
      check("rst_state", 32'(fsm_state), 32'(S_IDLE));
      check("rst_flags", {29'b0, halted, illegal_op, bus_error}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      tick(32'h0);

      // Reset asserted while waiting for fetch memory.
      run = 1'b1;
      mem_en = 1'b0;
      tick(32'h4);
      tick(32'h0010_0001);
      tick(32'h0);
      tick(32'h0);
      check("f1w_state", 32'(fsm_state), 32'(S_F1W));
      #2 rst = 1'b1;
      #1;
      check("async_rst_word", control_signal, 32'h0);
      check("async_rst_state", 32'(fsm_state), 32'(S_IDLE));
      @(negedge clk);
      rst = 1'b0;
      mem_en = 1'b1;
      pc_inc_cnt = 0;

      // LOAD with memory answering two cycles after each pulse.
      mem_lat = 2;
      fetch(8'h02, 1'b0);
      tick(32'h20); tick(32'h1); tick(32'h0); tick(32'h0); tick(32'h100); tick(32'h10000);
      mem_lat = 1;

      foreach (vecs[k]) begin
         fetch(vecs[k].op, vecs[k].neg);
         for (int i = 0; i < vecs[k].n; i++) tick(vecs[k].w[i]);
      end

      // MPY with the ALU busy for five cycles.
      mpy_lat = 5;
      fetch(8'h08, 1'b0);
      tick(32'h20); tick(32'h1); tick(32'h0); tick(32'h100); tick(32'h40000);
      repeat (5) tick(32'h0);
      mpy_lat = 0;

      // run dropped mid-instruction: LOAD completes, then IDLE.
      fetch(8'h02, 1'b0);
      tick(32'h20);
      tick(32'h1);
      run = 1'b0;
      tick(32'h0); tick(32'h100); tick(32'h10000);
      tick(32'h0); tick(32'h0);
      check("run_drop_idle", 32'(fsm_state), 32'(S_IDLE));
      check("pc_inc_once", pc_inc_cnt, n_instr);

      // Memory timeout on the LOAD read.
      run = 1'b1;
      fetch(8'h02, 1'b0);
      tick(32'h20);
      mem_en = 1'b0;
      tick(32'h1);
      repeat (MEM_TIMEOUT - 1) tick(32'h0);
      check("bus_err_early", {31'b0, bus_error}, 32'h0);
      tick(32'h0);
      check("bus_err_set", {31'b0, bus_error}, 32'h1);
      check("bus_err_halted", {31'b0, halted}, 32'h1);
      check("bus_err_state", 32'(fsm_state), 32'(S_HALT));
      mem_en = 1'b1;
      do_reset();
      check("post_rst_flags", {29'b0, halted, illegal_op, bus_error}, 32'h0);

      // Illegal opcode halts for good.
      fetch(8'hFF, 1'b0);
      tick(32'h0);
      check("illegal_flag", {31'b0, illegal_op}, 32'h1);
      check("illegal_halted", {31'b0, halted}, 32'h1);
      repeat (100) tick(32'h0);
      check("illegal_state", 32'(fsm_state), 32'(S_HALT));
      do_reset();

      // HALT opcode.
      fetch(8'h07, 1'b0);
      tick(32'h0);
      check("halt_halted", {31'b0, halted}, 32'h1);
      check("halt_not_illegal", {31'b0, illegal_op}, 32'h0);
      repeat (5) tick(32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
